pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 110 +++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding and default timing constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_STABLE_CYCLES       = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

  // The counter only ever holds values up to (largest period - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait with bounded retries, lock stabilisation and run-time lock monitoring.
// Every output is a flop loaded from the next state, so outputs change on the same edge as the state.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             locked,
  input  logic                             relock_req,
  output logic                             pll_rst,
  output logic                             sys_rst,
  output logic                             ready,
  output logic                             fault,
  output logic                             lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRIES);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr;
  logic [RTY_W-1:0]   retry_inc;
  logic [RTY_W-1:0]   retry_next;
  logic               locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  assign retry_inc = retry_cnt + 1'b1;

  always_comb begin
    next_state = state;
    retry_next = retry_cnt;
    if (relock_req) begin
      next_state = ST_RESET_PLL;
      retry_next = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt == RST_LAST) next_state = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            next_state = ST_STABILIZE;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_next = retry_inc;
            next_state = (retry_inc == RTY_MAX) ? ST_FAULT : ST_RESET_PLL;
          end
        end
        ST_STABILIZE: begin
          if (!locked_s)                next_state = ST_WAIT_LOCK;
          else if (cnt == STABLE_LAST)  next_state = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s) begin
            next_state = ST_RESET_PLL;
            retry_next = '0;
          end
        end
        ST_FAULT: next_state = ST_FAULT;
        default:  next_state = ST_RESET_PLL;
      endcase
    end
  end

  // relock_req restarts the count even when the state does not change (RESET_PLL).
  assign cnt_clr = relock_req || (next_state != state);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state <= next_state;
      // RUN and FAULT have no time limit, so the counter is parked there to avoid wrapping.
      if (cnt_clr || state == ST_RUN || state == ST_FAULT) cnt <= '0;
      else                                                 cnt <= cnt + 1'b1;
      retry_cnt <= retry_next;
      pll_rst   <= (next_state == ST_RESET_PLL) || (next_state == ST_FAULT);
      ready     <= (next_state == ST_RUN);
      sys_rst   <= (next_state != ST_RUN);
      fault     <= (next_state == ST_FAULT);
      lock_lost <= (state == ST_RUN) && !locked_s;
    end
  end

endmodule
